// File: rtl/if_fetch_icache_pkg.sv
// Shared constants and types for the instruction-fetch stage and its cache array.
// Memory-controller request encoding, fetch FSM states and instruction widths live here.
package if_fetch_icache_pkg;

  localparam int ADDR_W     = 32;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  localparam logic [2:0] LEN_WORD = 3'd4;
  localparam int         PORT_IF  = 0;
  localparam int         PORT_MEM = 1;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(INST_BYTES);
  endfunction

endpackage

// File: rtl/if_fetch_icache_array.sv
// Direct-mapped instruction cache storage: one word per line, combinational read,
// synchronous fill, valid bits cleared asynchronously by reset.
module icache_dm_array
  import if_fetch_icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = ADDR_W - INDEX_BITS - 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [INST_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [INST_W-1:0]     wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [INST_W-1:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/if_fetch_icache.sv
// Instruction-fetch stage: PC, direct-mapped icache lookup, single-word miss refill
// through controller port 0, and a valid/stall handshake towards decode.
module if_fetch_icache
  import if_fetch_icache_pkg::*;
#(
  parameter int          INDEX_BITS = 6,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        stall_in,
  input  logic        br_en,
  input  logic [31:0] br_target,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        mc_re,
  output logic        mc_we,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_len,
  input  logic [31:0] mc_r_data,
  input  logic        mc_busy,
  input  logic        mc_done
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  fetch_state_e state_q, state_d;

  logic [31:0]           pc_q, pc_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [31:0]           inst_q, inst_d;
  logic [31:0]           inst_pc_q, inst_pc_d;
  logic                  discard_q, discard_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]      miss_tag_q, miss_tag_d;

  logic [INDEX_BITS-1:0] lu_idx;
  logic [TAG_W-1:0]      lu_tag;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [INST_W-1:0]     rd_data;
  logic                  hit;
  logic                  slot_free;
  logic                  issue;
  logic                  fill;

  assign lu_idx    = pc_q[INDEX_BITS+1:2];
  assign lu_tag    = pc_q[31:INDEX_BITS+2];
  assign hit       = rd_valid && (rd_tag == lu_tag);
  assign slot_free = !inst_valid_q || !stall_in;

  icache_dm_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_idx   (lu_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_idx   (miss_idx_q),
    .wr_tag   (miss_tag_q),
    .wr_data  (mc_r_data)
  );

  // FSM state register; rdy_in=0 freezes everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      state_q <= ST_RUN;
    else if (rdy_in) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:       if (!br_en && slot_free && !hit) state_d = ST_MISS_REQ;
      ST_MISS_REQ:  if (br_en) state_d = ST_RUN;
                    else if (!mc_busy) state_d = ST_MISS_WAIT;
      ST_MISS_WAIT: if (mc_done) state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase
  end

  // A redirect in MISS_REQ suppresses the request that cycle, so nothing is left in flight.
  always_comb begin
    issue   = rdy_in && (state_q == ST_MISS_REQ) && !mc_busy && !br_en;
    fill    = rdy_in && (state_q == ST_MISS_WAIT) && mc_done;
    mc_re   = issue;
    mc_addr = issue ? pc_q : 32'h0;
    mc_we   = 1'b0;
    mc_len  = LEN_WORD;
  end

  always_comb begin
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    discard_d    = discard_q;
    miss_idx_d   = miss_idx_q;
    miss_tag_d   = miss_tag_q;
    if (br_en) begin
      inst_valid_d = 1'b0;
      pc_d         = br_target;
      // An in-flight refill still lands in the cache, but its word must not reach decode.
      discard_d    = (state_q == ST_MISS_WAIT) && !mc_done;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (slot_free) begin
            if (hit) begin
              inst_valid_d = 1'b1;
              inst_d       = rd_data;
              inst_pc_d    = pc_q;
              pc_d         = next_pc(pc_q);
            end else begin
              inst_valid_d = 1'b0;
            end
          end
        end
        ST_MISS_REQ: begin
          if (issue) begin
            miss_idx_d = lu_idx;
            miss_tag_d = lu_tag;
          end
        end
        ST_MISS_WAIT: begin
          if (mc_done) begin
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              inst_valid_d = 1'b1;
              inst_d       = mc_r_data;
              inst_pc_d    = pc_q;
              pc_d         = next_pc(pc_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      discard_q    <= 1'b0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
    end else if (rdy_in) begin
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      discard_q    <= discard_d;
      miss_idx_q   <= miss_idx_d;
      miss_tag_q   <= miss_tag_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule
